// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
// Source indices, vector layout and dispatch state encoding.
package irq_pkg;

   localparam int IRQ_VBLANK = 0;
   localparam int IRQ_STAT   = 1;
   localparam int IRQ_TIMER  = 2;
   localparam int IRQ_SERIAL = 3;
   localparam int IRQ_JOYPAD = 4;

   localparam logic [7:0] VEC_BASE   = 8'h40;
   localparam int         VEC_STRIDE = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } disp_st_t;

   function automatic logic [7:0] vec_of(input int idx);
      return VEC_BASE + 8'(VEC_STRIDE * idx);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder.
// Bit 0 has the highest priority.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      o_idx = '0;
      o_any = |i_req;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[k]) o_idx = IW'(k);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: IF/IE registers, edge capture,
// prioritised request and vector dispatch handshake.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int NUM_SRC      = 5,
   parameter int DISPATCH_LAT = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       irq_vblank,
   input  logic       irq_stat,
   input  logic       irq_timer,
   input  logic       irq_serial,
   input  logic       irq_joypad,
   input  logic       cpu_sel_if,
   input  logic       cpu_sel_ie,
   input  logic       cpu_wr,
   input  logic [7:0] cpu_di,
   output logic [7:0] cpu_do,
   output logic       int_req,
   input  logic       int_ack,
   output logic [7:0] int_vec,
   output logic       int_vec_valid,
   output logic       busy
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CW = (DISPATCH_LAT > 1) ? $clog2(DISPATCH_LAT) : 1;

   disp_st_t             r_state;
   disp_st_t             w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [NUM_SRC-1:0]   r_if;
   logic [NUM_SRC-1:0]   w_if_wr;
   logic [NUM_SRC-1:0]   w_if_nxt;
   logic [NUM_SRC-1:0]   r_src;
   logic [NUM_SRC-1:0]   w_src;
   logic [NUM_SRC-1:0]   w_rise;
   logic [NUM_SRC-1:0]   w_pend;
   logic [NUM_SRC-1:0]   w_clr;
   logic [7:0]           r_ie;
   logic [7:0]           w_ie_nxt;
   logic [7:0]           r_vec;
   logic [7:0]           w_vec_nxt;
   logic [IW-1:0]        w_idx;
   logic                 w_any;

   always_comb begin
      w_src             = '0;
      w_src[IRQ_VBLANK] = irq_vblank;
      w_src[IRQ_STAT]   = irq_stat;
      w_src[IRQ_TIMER]  = irq_timer;
      w_src[IRQ_SERIAL] = irq_serial;
      w_src[IRQ_JOYPAD] = irq_joypad;
   end

   assign w_rise = w_src & ~r_src;
   assign w_pend = r_if & r_ie[NUM_SRC-1:0];

   irq_prio_enc #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_enc (
      .i_req (w_pend),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_vec_nxt   = r_vec;
      w_clr       = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (int_ack) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = CW'(DISPATCH_LAT - 1);
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
               // Nothing left pending: cancelled dispatch
               if (w_any) begin
                  w_clr     = NUM_SRC'(1) << w_idx;
                  w_vec_nxt = vec_of(int'(w_idx));
               end else begin
                  w_vec_nxt = 8'h00;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // CPU load, then dispatch clear, then hardware rise wins
   always_comb begin
      w_ie_nxt = (cpu_wr && cpu_sel_ie) ? cpu_di : r_ie;
      w_if_wr  = (cpu_wr && cpu_sel_if) ? cpu_di[NUM_SRC-1:0] : r_if;
      w_if_nxt = (w_if_wr & ~w_clr) | w_rise;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_if    <= '0;
         r_ie    <= '0;
         r_src   <= '0;
         r_vec   <= '0;
      end else if (ce) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_if    <= w_if_nxt;
         r_ie    <= w_ie_nxt;
         r_src   <= w_src;
         r_vec   <= w_vec_nxt;
      end
   end

   always_comb begin
      cpu_do = 8'hFF;
      if (cpu_sel_if) cpu_do = {{(8 - NUM_SRC){1'b1}}, r_if};
      else if (cpu_sel_ie) cpu_do = r_ie;
   end

   assign int_req       = |w_pend;
   assign int_vec       = r_vec;
   assign int_vec_valid = (r_state == ST_DONE);
   assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: dispatches push expected
// vectors; a monitor checks each valid pulse.
module tb_irq_ctrl;

   localparam int DLAT = 2;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       ce;
   logic       irq_vblank, irq_stat, irq_timer;
   logic       irq_serial, irq_joypad;
   logic       cpu_sel_if, cpu_sel_ie, cpu_wr;
   logic [7:0] cpu_di;
   logic [7:0] cpu_do;
   logic       int_req;
   logic       int_ack;
   logic [7:0] int_vec;
   logic       int_vec_valid;
   logic       busy;

   typedef struct {
      logic [7:0] vec;
      int         ce;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   ce_cnt = 0;
   logic prev_v = 1'b0;

   irq_ctrl #(
      .NUM_SRC      (5),
      .DISPATCH_LAT (DLAT)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .ce            (ce),
      .irq_vblank    (irq_vblank),
      .irq_stat      (irq_stat),
      .irq_timer     (irq_timer),
      .irq_serial    (irq_serial),
      .irq_joypad    (irq_joypad),
      .cpu_sel_if    (cpu_sel_if),
      .cpu_sel_ie    (cpu_sel_ie),
      .cpu_wr        (cpu_wr),
      .cpu_di        (cpu_di),
      .cpu_do        (cpu_do),
      .int_req       (int_req),
      .int_ack       (int_ack),
      .int_vec       (int_vec),
      .int_vec_valid (int_vec_valid),
      .busy          (busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // One ce cycle followed by one gated-off clock
   task automatic step();
      ce = 1'b1;
      ce_cnt++;
      @(negedge clk_sys);
      ce = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic wr_if(input logic [7:0] v);
      cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = v;
      step();
      cpu_sel_if = 1'b0; cpu_wr = 1'b0;
   endtask

   task automatic wr_ie(input logic [7:0] v);
      cpu_sel_ie = 1'b1; cpu_wr = 1'b1; cpu_di = v;
      step();
      cpu_sel_ie = 1'b0; cpu_wr = 1'b0;
   endtask

   task automatic rd_if(input string nm, input logic [7:0] exp);
      cpu_sel_if = 1'b1;
      #1 chk(nm, cpu_do, exp);
      cpu_sel_if = 1'b0;
   endtask

   task automatic rd_ie(input string nm, input logic [7:0] exp);
      cpu_sel_ie = 1'b1;
      #1 chk(nm, cpu_do, exp);
      cpu_sel_ie = 1'b0;
   endtask

   task automatic dispatch(input logic [7:0] v);
      int_ack = 1'b1;
      step();
      sb.push_back('{vec: v, ce: ce_cnt});
      int_ack = 1'b0;
      chk("busy_wait", {7'd0, busy}, 8'd1);
      repeat (DLAT + 1) step();
   endtask

   // Valid is first seen after the sampling ce and is
   // presented to the CPU on the following ce.
   always @(negedge clk_sys) begin
      if (int_vec_valid && !prev_v) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got vec %h, want none",
                     int_vec);
         end else begin
            mon_e = sb.pop_front();
            chk("vec", int_vec, mon_e.vec);
            chk("latency", 8'(ce_cnt + 1 - mon_e.ce), 8'(DLAT + 1));
         end
      end
      prev_v = int_vec_valid;
   end

   initial begin
      reset_n = 1'b0; ce = 1'b0; int_ack = 1'b0;
      irq_vblank = 1'b0; irq_stat = 1'b0; irq_timer = 1'b0;
      irq_serial = 1'b0; irq_joypad = 1'b0;
      cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0; cpu_wr = 1'b0;
      cpu_di = 8'h00;
      repeat (2) @(negedge clk_sys);
      chk("rst_req", {7'd0, int_req}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_valid", {7'd0, int_vec_valid}, 8'd0);
      chk("rst_vec", int_vec, 8'h00);
      rd_if("rst_if", 8'hE0);
      rd_ie("rst_ie", 8'h00);
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Register access
      wr_ie(8'hFF);
      rd_ie("ie_ff", 8'hFF);
      wr_if(8'h00);
      rd_if("if_00", 8'hE0);
      #1 chk("unsel_rd", cpu_do, 8'hFF);
      chk("req_none", {7'd0, int_req}, 8'd0);

      // Timer pulse and single dispatch
      wr_ie(8'h04);
      irq_timer = 1'b1;
      step();
      irq_timer = 1'b0;
      step();
      rd_if("if_timer", 8'hE4);
      chk("req_timer", {7'd0, int_req}, 8'd1);
      dispatch(8'h50);
      rd_if("if_after_t", 8'hE0);
      chk("busy_idle", {7'd0, busy}, 8'd0);
      chk("vec_hold", int_vec, 8'h50);

      // Priority order
      wr_if(8'h1F);
      wr_ie(8'h1F);
      dispatch(8'h40);
      dispatch(8'h48);
      dispatch(8'h50);
      rd_if("if_prio", 8'hF8);

      // Cancellation by IE write during WAIT
      wr_if(8'h04);
      wr_ie(8'h04);
      int_ack = 1'b1;
      step();
      sb.push_back('{vec: 8'h00, ce: ce_cnt});
      int_ack = 1'b0;
      wr_ie(8'h00);
      step();
      step();
      rd_if("if_cancel", 8'hE4);
      chk("vec_cancel", int_vec, 8'h00);

      // Held level sets IF only once
      wr_if(8'h00);
      irq_vblank = 1'b1;
      repeat (4) step();
      rd_if("if_vbl", 8'hE1);
      wr_if(8'h00);
      rd_if("if_vbl_clr", 8'hE0);
      repeat (5) step();
      rd_if("if_vbl_held", 8'hE0);
      irq_vblank = 1'b0;

      // Rise beats a same-ce CPU clear
      irq_stat = 1'b1;
      wr_if(8'h00);
      rd_if("if_stat", 8'hE2);
      irq_stat = 1'b0;
      step();

      // Rise beats a same-ce dispatch clear
      wr_if(8'h01);
      wr_ie(8'h01);
      int_ack = 1'b1;
      step();
      sb.push_back('{vec: 8'h40, ce: ce_cnt});
      int_ack = 1'b0;
      step();
      irq_vblank = 1'b1;
      step();
      irq_vblank = 1'b0;
      step();
      rd_if("if_rise_clr", 8'hE1);

      // Asynchronous reset mid-WAIT
      wr_if(8'h04);
      wr_ie(8'h04);
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      step();
      #2 reset_n = 1'b0;
      #1 chk("arst_busy", {7'd0, busy}, 8'd0);
      chk("arst_valid", {7'd0, int_vec_valid}, 8'd0);
      chk("arst_req", {7'd0, int_req}, 8'd0);
      chk("arst_vec", int_vec, 8'h00);
      rd_if("arst_if", 8'hE0);
      rd_ie("arst_ie", 8'h00);
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (5) step();
      chk("arst_idle", {7'd0, busy}, 8'd0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
